ysyx_22050854_booth_mul_iter: RTL and testbench

//  Parametrised iterative radix-4 Booth multiplier for the EXU. Retires one Booth digit per cycle

---
 rtl/ysyx_22050854_booth_mul_iter_pkg.sv | 22 ++
 rtl/ysyx_22050854_booth_mul_iter_if.sv | 27 ++
 rtl/ysyx_22050854_booth_mul_iter_sel.sv | 20 ++
 rtl/ysyx_22050854_booth_mul_iter.sv | 123 ++++++++++++
 tb/tb_ysyx_22050854_booth_mul_iter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050854_booth_mul_iter_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package ysyx_22050854_booth_mul_iter_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // mul_signed encodings: {a_signed, b_signed}
  localparam logic [1:0] MUL_SS = 2'b11;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_UU = 2'b00;

  typedef struct packed {
    logic neg;
    logic neg2;
    logic pos;
    logic pos2;
  } booth_sel_t;

endpackage

// File: rtl/ysyx_22050854_booth_mul_iter_if.sv
// Request/response bundle between the EXU and the Booth multiplier.
interface ysyx_22050854_booth_mul_iter_if #(
  parameter int WIDTH  = 64,
  parameter int WWIDTH = 32
);
  logic             mul_valid;
  logic             mul_ready;
  logic             flush;
  logic             mulw;
  logic [1:0]       mul_signed;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport master (
    output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  mul_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/ysyx_22050854_booth_mul_iter_sel.sv
// Radix-4 Booth digit decoder: 3-bit window to one-hot multiple select.
module ysyx_22050854_booth_sel
  import ysyx_22050854_booth_mul_iter_pkg::*;
(
  input  logic [2:0]  i_window,
  output booth_sel_t  o_sel
);

  always_comb begin
    o_sel = '0;
    unique case (i_window)
      3'b001, 3'b010: o_sel.pos  = 1'b1;
      3'b011:         o_sel.pos2 = 1'b1;
      3'b100:         o_sel.neg2 = 1'b1;
      3'b101, 3'b110: o_sel.neg  = 1'b1;
      default:        o_sel      = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22050854_booth_mul_iter.sv
// Iterative radix-4 Booth multiplier: one digit per cycle into a 2*WIDTH accumulator,
// RV64M signedness modes plus MULW, valid/ready on both sides, flushable.
module ysyx_22050854_booth_mul_iter
  import ysyx_22050854_booth_mul_iter_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int WWIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  ysyx_22050854_booth_mul_iter_if.slave io_mul
);

  localparam int DIGITS  = (WIDTH + 2) / 2;
  localparam int WDIGITS = (WWIDTH + 2) / 2;
  localparam int CNTW    = $clog2(DIGITS);
  localparam int PW      = 2 * WIDTH;
  localparam int BW      = WIDTH + 2;

  mul_state_e       r_state, w_stateNext;
  logic [CNTW-1:0]  r_count;
  logic [BW-1:0]    r_b;
  logic             r_bPrev;
  logic [PW-1:0]    r_a;
  logic [PW-1:0]    r_acc;
  logic             r_mulw;
  logic [WIDTH-1:0] r_resHi, r_resLo;

  logic             w_accept, w_lastDigit, w_mulReady, w_outValid, w_cin;
  logic [PW-1:0]    w_aExt, w_mult, w_pp, w_accNext;
  logic [BW-1:0]    w_bExt;
  logic [WIDTH-1:0] w_prodHi, w_prodLo;
  booth_sel_t       w_sel;

  assign w_accept    = (r_state == MUL_IDLE) & io_mul.mul_valid & ~io_mul.flush;
  assign w_lastDigit = (r_count == (r_mulw ? CNTW'(WDIGITS - 1) : CNTW'(DIGITS - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MUL_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_mulReady  = 1'b0;
    w_outValid  = 1'b0;
    unique case (r_state)
      MUL_IDLE: begin
        w_mulReady = 1'b1;
        if (w_accept) w_stateNext = MUL_BUSY;
      end
      MUL_BUSY: begin
        if (io_mul.flush)     w_stateNext = MUL_IDLE;
        else if (w_lastDigit) w_stateNext = MUL_DONE;
      end
      MUL_DONE: begin
        w_outValid = 1'b1;
        if (io_mul.flush || io_mul.out_ready) w_stateNext = MUL_IDLE;
      end
      default: w_stateNext = MUL_IDLE;
    endcase
  end

  // A lives pre-extended to 2*WIDTH so every multiple is already sign-extended.
  assign w_aExt = io_mul.mulw
    ? {{(PW - WWIDTH){io_mul.multiplicand[WWIDTH-1]}}, io_mul.multiplicand[WWIDTH-1:0]}
    : {{WIDTH{io_mul.mul_signed[1] & io_mul.multiplicand[WIDTH-1]}}, io_mul.multiplicand};
  assign w_bExt = io_mul.mulw
    ? {{(BW - WWIDTH){io_mul.multiplier[WWIDTH-1]}}, io_mul.multiplier[WWIDTH-1:0]}
    : {{2{io_mul.mul_signed[0] & io_mul.multiplier[WIDTH-1]}}, io_mul.multiplier};

  ysyx_22050854_booth_sel u_sel (
    .i_window ({r_b[1:0], r_bPrev}),
    .o_sel    (w_sel)
  );

  // Negative multiples are ~M with the +1 supplied as adder carry-in.
  assign w_mult    = (w_sel.pos2 | w_sel.neg2) ? (r_a << 1) : r_a;
  assign w_pp      = (w_sel.pos | w_sel.pos2) ? w_mult :
                     (w_sel.neg | w_sel.neg2) ? ~w_mult : '0;
  assign w_cin     = w_sel.neg | w_sel.neg2;
  assign w_accNext = r_acc + w_pp + PW'(w_cin);

  assign w_prodLo = r_mulw ? {{(WIDTH - WWIDTH){w_accNext[WWIDTH-1]}}, w_accNext[WWIDTH-1:0]}
                           : w_accNext[WIDTH-1:0];
  assign w_prodHi = r_mulw ? {WIDTH{w_accNext[WWIDTH-1]}} : w_accNext[PW-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_b     <= '0;
      r_bPrev <= 1'b0;
      r_a     <= '0;
      r_acc   <= '0;
      r_mulw  <= 1'b0;
      r_resHi <= '0;
      r_resLo <= '0;
    end else if (w_accept) begin
      r_count <= '0;
      r_b     <= w_bExt;
      r_bPrev <= 1'b0;
      r_a     <= w_aExt;
      r_acc   <= '0;
      r_mulw  <= io_mul.mulw;
    end else if (r_state == MUL_BUSY && !io_mul.flush) begin
      r_count <= r_count + CNTW'(1);
      r_b     <= {{2{r_b[BW-1]}}, r_b[BW-1:2]};
      r_bPrev <= r_b[1];
      r_a     <= r_a << 2;
      r_acc   <= w_accNext;
      if (w_lastDigit) begin
        r_resHi <= w_prodHi;
        r_resLo <= w_prodLo;
      end
    end
  end

  assign io_mul.mul_ready = w_mulReady;
  assign io_mul.out_valid = w_outValid;
  assign io_mul.result_hi = r_resHi;
  assign io_mul.result_lo = r_resLo;

endmodule

// File: tb/tb_ysyx_22050854_booth_mul_iter.sv
// Directed and reference-model checks for the iterative Booth multiplier (WIDTH=64, WWIDTH=32).
module tb_ysyx_22050854_booth_mul_iter;
  import ysyx_22050854_booth_mul_iter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ysyx_22050854_booth_mul_iter_if #(.WIDTH(64), .WWIDTH(32)) bus ();

  ysyx_22050854_booth_mul_iter #(.WIDTH(64), .WWIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_mul (bus)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] refProd(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] sg, input logic w);
    logic signed [63:0] p64;
    logic [127:0]       ax, bx;
    if (w) begin
      p64 = $signed(a[31:0]) * $signed(b[31:0]);
      return {{96{p64[31]}}, p64[31:0]};
    end
    ax = sg[1] ? {{64{a[63]}}, a} : {64'b0, a};
    bx = sg[0] ? {{64{b[63]}}, b} : {64'b0, b};
    return ax * bx;
  endfunction

  task automatic startOp(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] sg, input logic w);
    @(negedge clk);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.mul_signed   = sg;
    bus.mulw         = w;
    bus.mul_valid    = 1'b1;
    @(posedge clk);
    #1;
    bus.mul_valid    = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
  endtask

  // Counts edges after the accepting edge until out_valid is seen; bounded.
  task automatic waitDone(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) break;
    end
  endtask

  task automatic finishOp(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_vldDrop"}, 128'(bus.out_valid), 128'(0));
  endtask

  task automatic applyStimulus(input string tag, input logic [63:0] a, input logic [63:0] b,
                               input logic [1:0] sg, input logic w,
                               input logic [127:0] expP, input int expLat);
    int lat;
    checkOutput({tag, "_rdy"}, 128'(bus.mul_ready), 128'(1));
    startOp(a, b, sg, w);
    waitDone(lat);
    checkOutput({tag, "_lat"}, 128'(lat), 128'(expLat));
    checkOutput({tag, "_hi"}, 128'(bus.result_hi), {64'b0, expP[127:64]});
    checkOutput({tag, "_lo"}, 128'(bus.result_lo), {64'b0, expP[63:0]});
    finishOp(tag);
  endtask

  initial begin
    int          lat;
    int          sawValid;
    logic [63:0] ra, rb;
    logic [1:0]  rsg;
    logic        rw;

    bus.mul_valid    = 1'b0;
    bus.flush        = 1'b0;
    bus.mulw         = 1'b0;
    bus.mul_signed   = MUL_UU;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.out_ready    = 1'b0;

    #1;
    checkOutput("rst_rdy", 128'(bus.mul_ready), 128'(1));
    checkOutput("rst_vld", 128'(bus.out_valid), 128'(0));
    checkOutput("rst_hi", 128'(bus.result_hi), 128'(0));
    checkOutput("rst_lo", 128'(bus.result_lo), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus("mulSS", -64'sd3, 64'd5, MUL_SS, 1'b0,
                  {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF1}, 33);
    applyStimulus("mulUU", 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, MUL_UU, 1'b0,
                  {64'hFFFFFFFFFFFFFFFE, 64'h1}, 33);
    applyStimulus("mulSU", 64'hFFFFFFFFFFFFFFFF, 64'd2, MUL_SU, 1'b0,
                  {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE}, 33);
    applyStimulus("mulUU2", 64'hFFFFFFFFFFFFFFFF, 64'd2, MUL_UU, 1'b0,
                  {64'h1, 64'hFFFFFFFFFFFFFFFE}, 33);
    applyStimulus("mulw", 64'h7FFFFFFF, 64'd2, MUL_UU, 1'b1,
                  {64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE}, 17);

    // Flush in IDLE together with a request: the request must not be taken.
    @(negedge clk);
    bus.mul_valid = 1'b1;
    bus.flush     = 1'b1;
    @(posedge clk);
    #1;
    bus.mul_valid = 1'b0;
    bus.flush     = 1'b0;
    checkOutput("idleFlush_rdy", 128'(bus.mul_ready), 128'(1));

    // Back-pressure: hold DONE with a pending request waiting behind it.
    startOp(64'd6, 64'd7, MUL_SS, 1'b0);
    waitDone(lat);
    checkOutput("bp_lat", 128'(lat), 128'(33));
    bus.multiplicand = 64'd3;
    bus.multiplier   = 64'd4;
    bus.mul_signed   = MUL_UU;
    bus.mulw         = 1'b0;
    bus.mul_valid    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_vld", 128'(bus.out_valid), 128'(1));
      checkOutput("bp_rdy", 128'(bus.mul_ready), 128'(0));
      checkOutput("bp_lo", 128'(bus.result_lo), 128'(42));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("bp_hsVld", 128'(bus.out_valid), 128'(0));
    checkOutput("bp_hsRdy", 128'(bus.mul_ready), 128'(1));
    checkOutput("bp_holdLo", 128'(bus.result_lo), 128'(42));
    @(posedge clk);
    #1;
    bus.mul_valid = 1'b0;
    checkOutput("bp_accept", 128'(bus.mul_ready), 128'(0));
    waitDone(lat);
    checkOutput("bp2_lat", 128'(lat), 128'(33));
    checkOutput("bp2_lo", 128'(bus.result_lo), 128'(12));
    finishOp("bp2");

    // Flush on the 10th BUSY edge: no result, previous result retained.
    startOp(64'd11, 64'd13, MUL_UU, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkOutput("flush_rdy", 128'(bus.mul_ready), 128'(1));
    sawValid = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) sawValid = 1;
    end
    checkOutput("flush_noVld", 128'(sawValid), 128'(0));
    checkOutput("flush_holdLo", 128'(bus.result_lo), 128'(12));
    applyStimulus("postFlush", 64'd6, 64'd7, MUL_UU, 1'b0, 128'd42, 33);

    // Asynchronous reset mid-BUSY clears outputs without waiting for an edge.
    startOp(64'd9, 64'd9, MUL_UU, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRst_rdy", 128'(bus.mul_ready), 128'(1));
    checkOutput("midRst_vld", 128'(bus.out_valid), 128'(0));
    checkOutput("midRst_hi", 128'(bus.result_hi), 128'(0));
    checkOutput("midRst_lo", 128'(bus.result_lo), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("postRst", -64'sd2, -64'sd4, MUL_SS, 1'b0, 128'd8, 33);

    for (int i = 0; i < 120; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      if (i % 8 == 7) ra = 64'h8000000000000000;
      if (i % 16 == 15) rb = 64'hFFFFFFFFFFFFFFFF;
      rw  = (i % 4 == 3);
      rsg = (i % 4 == 0) ? MUL_SS : (i % 4 == 1) ? MUL_SU : (i % 4 == 2) ? MUL_UU
                                                           : 2'($urandom_range(0, 3));
      applyStimulus("rand", ra, rb, rsg, rw, refProd(ra, rb, rsg, rw), rw ? 17 : 33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
